// File: rtl/dma_write_drain_pkg.sv
// Shared types and sizes for the dcache DMA write drain path.
// Holds the stage-3 DMA instruction layout, the FIFO entry layout, the drain FSM
// state encoding and all derived widths.
package dma_write_drain_pkg;

    localparam int unsigned TILE_WIDTH       = 288;
    localparam int unsigned BEAT_WIDTH       = 72;
    localparam int unsigned BEATS            = TILE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_IDX_W       = $clog2(BEATS);
    localparam int unsigned FIFO_DEPTH       = 4;
    localparam int unsigned FIFO_CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MEM_ADDR_WIDTH   = 24;
    localparam int unsigned WR_ADDR_WIDTH    = MEM_ADDR_WIDTH + BEAT_IDX_W;
    localparam int unsigned CACHE_SLOT_WIDTH = 2;
    localparam int unsigned CACHE_ADDR_WIDTH = 8;
    localparam int unsigned DONE_WIDTH       = 16;

    // DMA control word travelling alongside the tile from the dcache
    typedef struct packed {
        logic                        valid;
        logic                        mem_we;
        logic [MEM_ADDR_WIDTH-1:0]   mem_addr;
        logic [CACHE_SLOT_WIDTH-1:0] cache_slot;
        logic [CACHE_ADDR_WIDTH-1:0] cache_addr;
    } dma_raw_instr;

    typedef struct packed {
        dma_raw_instr          raw_instr_data;
        logic [TILE_WIDTH-1:0] dat;
    } dma_stage_3_instr;

    // One buffered tile: destination address plus payload
    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] mem_addr;
        logic [TILE_WIDTH-1:0]     dat;
    } wr_tile_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

endpackage

// File: rtl/dma_wr_fifo.sv
// Synchronous tile FIFO feeding the write-drain serializer.
// Ports: clk, reset (async active-low), push_i/wdata_i (write), pop_i/rdata_o
// (show-ahead read of the head entry), full_o, empty_o, count_o (occupancy).
// A push while full is accepted only when a pop happens on the same edge.
module dma_wr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_write_drain.sv
// Drains dcache DMA write tiles to the main-memory write bus as narrow beats.
// Ports: clk, reset (async active-low), freeze (blocks enqueue only),
// dma_write_port (stage-3 instr + tile), mem_wr_* (valid/ready beat bus with
// {mem_addr, beat_idx} address, LSB-first data, last flag), stall_req (buffer
// near full), idle, overflow (sticky drop flag), tiles_done (wrapping count).
module dma_write_drain
    import dma_write_drain_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     freeze,
    input  dma_stage_3_instr         dma_write_port,
    output logic                     mem_wr_valid,
    input  logic                     mem_wr_ready,
    output logic [WR_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [BEAT_WIDTH-1:0]    mem_wr_data,
    output logic                     mem_wr_last,
    output logic                     stall_req,
    output logic                     idle,
    output logic                     overflow,
    output logic [DONE_WIDTH-1:0]    tiles_done
);

    drain_state_e              state_q;
    logic [TILE_WIDTH-1:0]     tile_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [BEAT_IDX_W-1:0]     beat_idx_q;
    logic                      valid_q;
    logic                      last_q;
    logic                      overflow_q;
    logic [DONE_WIDTH-1:0]     done_q;

    logic                      enq_req;
    logic                      handshake;
    logic                      last_hs;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_CNT_W-1:0]     fifo_count;
    logic [$bits(wr_tile_t)-1:0] fifo_wdata;
    logic [$bits(wr_tile_t)-1:0] fifo_rdata;
    wr_tile_t                  fifo_head;
    logic                      unused_fields;

    // Reads (mem_we==0) and frozen stale repeats never enqueue
    assign enq_req = !freeze
                  && dma_write_port.raw_instr_data.valid
                  && dma_write_port.raw_instr_data.mem_we;

    assign handshake = valid_q && mem_wr_ready;
    assign last_hs   = handshake && (beat_idx_q == BEAT_IDX_W'(BEATS - 1));
    // Load the serializer when idle, or back-to-back on the final beat
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || last_hs);

    assign fifo_wdata = {dma_write_port.raw_instr_data.mem_addr, dma_write_port.dat};
    assign fifo_head  = wr_tile_t'(fifo_rdata);

    assign unused_fields = ^{dma_write_port.raw_instr_data.cache_slot,
                             dma_write_port.raw_instr_data.cache_addr};

    dma_wr_fifo #(
        .WIDTH ($bits(wr_tile_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (enq_req),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Serializer FSM, tile shift register, beat counter, status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tile_q     <= '0;
            addr_q     <= '0;
            beat_idx_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= '0;
        end else begin
            if (enq_req && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            if (last_hs) done_q <= done_q + DONE_WIDTH'(1);

            if (fifo_pop) begin
                state_q    <= ST_SEND;
                tile_q     <= fifo_head.dat;
                addr_q     <= fifo_head.mem_addr;
                beat_idx_q <= '0;
                valid_q    <= 1'b1;
                last_q     <= (BEATS == 1);
            end else if (last_hs) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (handshake) begin
                // Shift so the next beat always sits in the low lanes
                tile_q     <= tile_q >> BEAT_WIDTH;
                beat_idx_q <= beat_idx_q + BEAT_IDX_W'(1);
                last_q     <= (beat_idx_q == BEAT_IDX_W'(BEATS - 2));
            end
        end
    end

    assign mem_wr_valid = valid_q;
    assign mem_wr_addr  = {addr_q, beat_idx_q};
    assign mem_wr_data  = tile_q[BEAT_WIDTH-1:0];
    assign mem_wr_last  = last_q;
    assign overflow     = overflow_q;
    assign tiles_done   = done_q;
    assign stall_req    = (fifo_count >= FIFO_CNT_W'(FIFO_DEPTH - 1));
    assign idle         = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_dma_write_drain.sv
// Self-checking bench for dma_write_drain: beat scoreboard built from whole
// tiles, table of single-tile cases, hand sequences for corner cases, and a
// randomized run against the same scoreboard.
module tb_dma_write_drain;
    import dma_write_drain_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     freeze;
    dma_stage_3_instr         dwp;
    logic                     mem_wr_valid;
    logic                     mem_wr_ready;
    logic [WR_ADDR_WIDTH-1:0] mem_wr_addr;
    logic [BEAT_WIDTH-1:0]    mem_wr_data;
    logic                     mem_wr_last;
    logic                     stall_req;
    logic                     idle;
    logic                     overflow;
    logic [DONE_WIDTH-1:0]    tiles_done;

    always #5 clk = ~clk;

    dma_write_drain dut (
        .clk            (clk),
        .reset          (reset),
        .freeze         (freeze),
        .dma_write_port (dwp),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_last    (mem_wr_last),
        .stall_req      (stall_req),
        .idle           (idle),
        .overflow       (overflow),
        .tiles_done     (tiles_done)
    );

    typedef struct {
        logic [WR_ADDR_WIDTH-1:0] addr;
        logic [BEAT_WIDTH-1:0]    data;
        logic                     last;
    } beat_t;

    typedef struct {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [7:0]                ready_pat;
        logic [WR_ADDR_WIDTH-1:0]  exp_addr0;
        int                        exp_done_inc;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    hs_count = 0;
    logic  stab_pend = 1'b0;
    logic [WR_ADDR_WIDTH-1:0] s_addr;
    logic [BEAT_WIDTH-1:0]    s_data;
    logic                     s_last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [TILE_WIDTH-1:0] rand_tile();
        logic [TILE_WIDTH-1:0] r;
        for (int i = 0; i < TILE_WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected beats of a tile: beat k is the k-th BEAT_WIDTH slice, address {tile, k}
    task automatic expect_tile(input logic [MEM_ADDR_WIDTH-1:0] a, input logic [TILE_WIDTH-1:0] d);
        beat_t b;
        for (int k = 0; k < int'(BEATS); k++) begin
            b.addr = WR_ADDR_WIDTH'(a) * WR_ADDR_WIDTH'(BEATS) + WR_ADDR_WIDTH'(k);
            b.data = d[k*BEAT_WIDTH +: BEAT_WIDTH];
            b.last = (k == int'(BEATS) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_in(input logic v, input logic we, input logic [MEM_ADDR_WIDTH-1:0] a,
                          input logic [TILE_WIDTH-1:0] d);
        dwp.raw_instr_data.valid      = v;
        dwp.raw_instr_data.mem_we     = we;
        dwp.raw_instr_data.mem_addr   = a;
        dwp.raw_instr_data.cache_slot = CACHE_SLOT_WIDTH'($urandom);
        dwp.raw_instr_data.cache_addr = CACHE_ADDR_WIDTH'($urandom);
        dwp.dat                       = d;
    endtask

    task automatic clr_in();
        set_in(1'b0, 1'b0, '0, '0);
    endtask

    // Checks hold-while-stalled and the beat about to be accepted, then advances one clock
    task automatic tick();
        beat_t b;
        if (stab_pend) begin
            chk("hold_valid", mem_wr_valid, 1);
            chk("hold_addr",  mem_wr_addr,  s_addr);
            chk("hold_data",  mem_wr_data,  s_data);
            chk("hold_last",  mem_wr_last,  s_last);
        end
        stab_pend = mem_wr_valid && !mem_wr_ready;
        s_addr = mem_wr_addr;
        s_data = mem_wr_data;
        s_last = mem_wr_last;
        if (mem_wr_valid && mem_wr_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual addr=%0h required=no beat", mem_wr_addr);
            end else begin
                b = exp_q.pop_front();
                chk("beat_addr", mem_wr_addr, b.addr);
                chk("beat_data", mem_wr_data, b.data);
                chk("beat_last", mem_wr_last, b.last);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !idle) && n < budget) begin
            tick();
            n++;
        end
        chk(name, (exp_q.size() == 0) && idle, 1);
    endtask

    initial begin
        vec_t                     vecs[5];
        logic [TILE_WIDTH-1:0]    d;
        logic [MEM_ADDR_WIDTH-1:0] a;
        logic [DONE_WIDTH-1:0]    base;
        int                       hs0;
        logic                     first_seen;
        logic                     we;
        int                       exp_tiles;
        logic [5:0]               exp_stall;
        logic [5:0]               exp_ovf;

        vecs[0] = '{24'h000001, 8'hFF,       26'h0000004, 1};
        vecs[1] = '{24'h000123, 8'b10011001, 26'h000048C, 1};
        vecs[2] = '{24'hABCDEF, 8'b01010101, 26'h2AF37BC, 1};
        vecs[3] = '{24'hFFFFFF, 8'b00010001, 26'h3FFFFFC, 1};
        vecs[4] = '{24'h000000, 8'b11100111, 26'h0000000, 1};

        reset        = 1'b0;
        freeze       = 1'b0;
        mem_wr_ready = 1'b0;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", mem_wr_valid, 0);
        chk("rst_addr",  mem_wr_addr, 0);
        chk("rst_data",  mem_wr_data, 0);
        chk("rst_last",  mem_wr_last, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_done",  tiles_done, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_idle",  idle, 1);
        reset = 1'b1;
        tick();

        // Single tile, ready high: first beat one cycle after enqueue, then 4 consecutive beats
        mem_wr_ready = 1'b1;
        d = rand_tile();
        set_in(1'b1, 1'b1, 24'h10, d);
        expect_tile(24'h10, d);
        tick();
        clr_in();
        chk("t1_valid_lat", mem_wr_valid, 0);
        chk("t1_idle_busy", idle, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", mem_wr_valid, 1);
            chk("t1_addr", mem_wr_addr, 128'h40 + 128'(k));
            tick();
        end
        chk("t1_valid_end", mem_wr_valid, 0);
        chk("t1_idle", idle, 1);
        chk("t1_done", tiles_done, 1);

        // Table of single tiles under different ready patterns
        foreach (vecs[i]) begin
            base = tiles_done;
            d = rand_tile();
            mem_wr_ready = 1'b0;
            set_in(1'b1, 1'b1, vecs[i].addr, d);
            expect_tile(vecs[i].addr, d);
            tick();
            clr_in();
            hs0 = hs_count;
            first_seen = 1'b0;
            for (int c = 0; c < 64 && (hs_count - hs0) < 4; c++) begin
                mem_wr_ready = vecs[i].ready_pat[c % 8];
                if (mem_wr_valid && !first_seen) begin
                    first_seen = 1'b1;
                    chk("vec_addr0", mem_wr_addr, vecs[i].exp_addr0);
                end
                tick();
            end
            chk("vec_beats", hs_count - hs0, 4);
            chk("vec_done", tiles_done, DONE_WIDTH'(base + DONE_WIDTH'(vecs[i].exp_done_inc)));
            chk("vec_idle", idle, 1);
        end

        // Three tiles back-to-back: twelve beats with no bubble
        mem_wr_ready = 1'b1;
        base = tiles_done;
        hs0 = hs_count;
        for (int t = 0; t < 3; t++) begin
            d = rand_tile();
            a = MEM_ADDR_WIDTH'(24'h200 + t);
            set_in(1'b1, 1'b1, a, d);
            expect_tile(a, d);
            tick();
        end
        clr_in();
        chk("t3_early_beats", hs_count - hs0, 1);
        for (int k = 0; k < 11; k++) begin
            chk("t3_no_bubble", mem_wr_valid, 1);
            tick();
        end
        chk("t3_beats", hs_count - hs0, 12);
        chk("t3_valid_end", mem_wr_valid, 0);
        chk("t3_done", tiles_done, DONE_WIDTH'(base + 16'd3));

        // Ready low, six pushes: one in serializer, four buffered, sixth dropped
        mem_wr_ready = 1'b0;
        base = tiles_done;
        exp_stall = 6'b111000;
        exp_ovf   = 6'b100000;
        for (int t = 0; t < 6; t++) begin
            d = rand_tile();
            a = MEM_ADDR_WIDTH'(24'h300 + t);
            set_in(1'b1, 1'b1, a, d);
            if (t < 5) expect_tile(a, d);
            tick();
            chk("t4_stall", stall_req, exp_stall[t]);
            chk("t4_ovf", overflow, exp_ovf[t]);
        end
        clr_in();
        mem_wr_ready = 1'b1;
        drain("t4_drain", 100);
        chk("t4_done", tiles_done, DONE_WIDTH'(base + 16'd5));
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_stall_end", stall_req, 0);

        // Frozen writes and reads never enqueue
        base = tiles_done;
        freeze = 1'b1;
        set_in(1'b1, 1'b1, 24'h77, rand_tile());
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_freeze_idle", idle, 1);
        end
        freeze = 1'b0;
        set_in(1'b1, 1'b0, 24'h78, rand_tile());
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_read_idle", idle, 1);
        end
        clr_in();
        tick();
        chk("t5_valid", mem_wr_valid, 0);
        chk("t5_done", tiles_done, base);

        // Reset in the middle of a tile abandons it
        mem_wr_ready = 1'b1;
        d = rand_tile();
        set_in(1'b1, 1'b1, 24'h55, d);
        expect_tile(24'h55, d);
        tick();
        clr_in();
        tick();
        tick();
        chk("t6_mid_valid", mem_wr_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", mem_wr_valid, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_last", mem_wr_last, 0);
        chk("t6_rst_addr", mem_wr_addr, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_done", tiles_done, 0);
        exp_q.delete();
        stab_pend = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_quiet", mem_wr_valid, 0);
        end
        d = rand_tile();
        set_in(1'b1, 1'b1, 24'h9, d);
        expect_tile(24'h9, d);
        tick();
        clr_in();
        drain("t6_drain", 50);
        chk("t6_done", tiles_done, 1);

        // Randomized traffic; the producer honours stall_req like the core does
        base = tiles_done;
        exp_tiles = 0;
        for (int c = 0; c < 400; c++) begin
            mem_wr_ready = ($urandom_range(0, 3) != 0);
            freeze = ($urandom_range(0, 7) == 0);
            if (!stall_req && ($urandom_range(0, 1) == 1)) begin
                we = ($urandom_range(0, 5) != 0);
                a = MEM_ADDR_WIDTH'($urandom);
                d = rand_tile();
                set_in(1'b1, we, a, d);
                if (!freeze && we) begin
                    expect_tile(a, d);
                    exp_tiles++;
                end
            end else begin
                clr_in();
            end
            tick();
        end
        freeze = 1'b0;
        clr_in();
        mem_wr_ready = 1'b1;
        drain("rand_drain", 200);
        chk("rand_done", tiles_done, DONE_WIDTH'(base + DONE_WIDTH'(exp_tiles)));
        chk("rand_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
